// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core: multi-cycle RV32I/RV32E integer core; optional MUL when RVCORE_MUL_EN is defined.
// Latency: 2 cycles per instruction (FETCH handshake, EXEC); writeback is visible 2 cycles after the handshake.
// Backpressure: instr_ready is high only in FETCH; a low instr_valid stalls in FETCH; HALT holds ready low until reset.
module rv_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        illegal
);

  localparam int         IW    = $clog2(NUM_REGS);
  localparam logic [5:0] NREGS = 6'(NUM_REGS);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t      state;
  logic [31:0] ir;
  logic [31:0] regs [NUM_REGS];

  // Decoded fields of the latched instruction word
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_b, imm_j;
  logic        rs1_ok, rs2_ok, rd_ok;
  logic [31:0] rv1, rv2;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // Indices beyond the register file (RV32E) are flagged illegal, never used to index
  assign rs1_ok = {1'b0, rs1} < NREGS;
  assign rs2_ok = {1'b0, rs2} < NREGS;
  assign rd_ok  = {1'b0, rd}  < NREGS;

  assign rv1 = (rs1_ok && rs1 != 5'd0) ? regs[rs1[IW-1:0]] : 32'd0;
  assign rv2 = (rs2_ok && rs2 != 5'd0) ? regs[rs2[IW-1:0]] : 32'd0;

  // ALU shared by R-type and I-type; sub selects SUB, arith selects SRA over SRL
  function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub, input logic arith,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'b000:  r = sub ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = arith ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  logic        ex_bad, ex_wr, taken;
  logic        use_rs1, use_rs2, use_rd;
  logic [31:0] ex_val, ex_npc, pc4, target;

  // Execute: legality, writeback value and next pc for the latched word
  always_comb begin
    ex_bad  = 1'b0;
    ex_wr   = 1'b0;
    taken   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    ex_val  = 32'd0;
    pc4     = pc + 32'd4;
    ex_npc  = pc4;
    target  = 32'd0;
    case (opcode)
      OP_R: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        ex_wr   = 1'b1;
        if (funct7 == 7'b0000000) begin
          ex_val = alu(funct3, 1'b0, 1'b0, rv1, rv2);
        end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          ex_val = alu(funct3, 1'b1, 1'b1, rv1, rv2);
        end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
`ifdef RVCORE_MUL_EN
          ex_val = rv1 * rv2;
`else
          ex_bad = 1'b1;
`endif
        end else begin
          ex_bad = 1'b1;
        end
      end
      OP_I: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        ex_wr   = 1'b1;
        if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
          ex_bad = 1'b1;
        end else if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          ex_bad = 1'b1;
        end
        ex_val = alu(funct3, 1'b0, ir[30], rv1, imm_i);
      end
      OP_LUI: begin
        use_rd = 1'b1;
        ex_wr  = 1'b1;
        ex_val = {ir[31:12], 12'd0};
      end
      OP_JAL: begin
        use_rd = 1'b1;
        ex_wr  = 1'b1;
        ex_val = pc4;
        target = pc + imm_j;
        ex_npc = target;
        if (target[1:0] != 2'b00) ex_bad = 1'b1;
      end
      OP_JALR: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        ex_wr   = 1'b1;
        ex_val  = pc4;
        target  = (rv1 + imm_i) & 32'hFFFF_FFFE;
        ex_npc  = target;
        if (funct3 != 3'b000 || target[1:0] != 2'b00) ex_bad = 1'b1;
      end
      OP_BR: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case (funct3)
          3'b000:  taken = (rv1 == rv2);
          3'b001:  taken = (rv1 != rv2);
          3'b100:  taken = ($signed(rv1) <  $signed(rv2));
          3'b101:  taken = ($signed(rv1) >= $signed(rv2));
          3'b110:  taken = (rv1 <  rv2);
          3'b111:  taken = (rv1 >= rv2);
          default: ex_bad = 1'b1;
        endcase
        ex_val = {31'd0, taken};
        target = pc + imm_b;
        if (taken) begin
          ex_npc = target;
          if (target[1:0] != 2'b00) ex_bad = 1'b1;
        end
      end
      default: ex_bad = 1'b1;
    endcase
    if ((use_rs1 && !rs1_ok) || (use_rs2 && !rs2_ok) || (use_rd && !rd_ok)) ex_bad = 1'b1;
  end

  assign instr_ready = (state == S_FETCH) && !reset;

  // FSM plus architectural state: fetch latch, execute commit, sticky halt
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      result       <= 32'd0;
      result_valid <= 1'b0;
      illegal      <= 1'b0;
      ir           <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            ir    <= instruction;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (ex_bad) begin
            illegal <= 1'b1;
            state   <= S_HALT;
          end else begin
            pc           <= ex_npc;
            result       <= ex_val;
            result_valid <= 1'b1;
            state        <= S_FETCH;
            if (ex_wr && rd != 5'd0) regs[rd[IW-1:0]] <= ex_val;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_core.sv
// tb_rv_multicycle_core: directed-vector bench for rv_multicycle_core (RV32E, RESET_PC=0x100).
// Latency: each instruction is checked in its EXEC cycle and two cycles after its handshake.
// Backpressure: stalls, halt and reset-during-EXEC are driven explicitly.
module tb_rv_multicycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] result;
  logic        result_valid;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rv_multicycle_core #(
    .RESET_PC(32'h0000_0100),
    .NUM_REGS(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instruction  (instruction),
    .pc           (pc),
    .result       (result),
    .result_valid (result_valid),
    .illegal      (illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for instr_ready at a falling edge
  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!instr_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready"}, 32'(instr_ready), 32'd1);
  endtask

  // Hand one word to the core and check EXEC and the commit cycle
  task automatic issue(input string tag, input logic [31:0] w, input logic exp_ill,
                       input logic [31:0] exp_res, input logic [31:0] exp_pc);
    wait_ready(tag);
    instr_valid = 1'b1;
    instruction = w;
    @(negedge clk);
    check({tag, "_exec_rdy"}, 32'(instr_ready), 32'd0);
    check({tag, "_exec_rv"}, 32'(result_valid), 32'd0);
    instruction = 32'hFFFF_FFFF;
    instr_valid = 1'b0;
    @(negedge clk);
    if (!exp_ill) begin
      check({tag, "_rv"}, 32'(result_valid), 32'd1);
      check({tag, "_res"}, result, exp_res);
      check({tag, "_pc"}, pc, exp_pc);
      check({tag, "_rdy"}, 32'(instr_ready), 32'd1);
    end else begin
      check({tag, "_ill"}, 32'(illegal), 32'd1);
      check({tag, "_ill_pc"}, pc, exp_pc);
      check({tag, "_ill_rv"}, 32'(result_valid), 32'd0);
      check({tag, "_ill_rdy"}, 32'(instr_ready), 32'd0);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check({tag, "_rst_rdy"}, 32'(instr_ready), 32'd0);
    check({tag, "_rst_pc"}, pc, 32'h100);
    check({tag, "_rst_res"}, result, 32'd0);
    check({tag, "_rst_rv"}, 32'(result_valid), 32'd0);
    check({tag, "_rst_ill"}, 32'(illegal), 32'd0);
    reset = 1'b0;
    #1;
    check({tag, "_rst_rdy1"}, 32'(instr_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset("r0");

    // ALU, compares, branches, jumps
    issue("addi_x1",  32'h0050_0093, 1'b0, 32'h0000_0005, 32'h104);
    issue("addi_x2",  32'hFFD0_0113, 1'b0, 32'hFFFF_FFFD, 32'h108);
    issue("slt",      32'h0011_21B3, 1'b0, 32'h0000_0001, 32'h10C);
    issue("bne",      32'h0020_9863, 1'b0, 32'h0000_0001, 32'h11C);
    issue("jal",      32'hFF9F_F2EF, 1'b0, 32'h0000_0120, 32'h114);
    issue("sltu",     32'h0011_31B3, 1'b0, 32'h0000_0000, 32'h118);
    issue("srai",     32'h4011_5213, 1'b0, 32'hFFFF_FFFE, 32'h11C);

    // Stall: five idle cycles in FETCH
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_pc", pc, 32'h11C);
      check("stall_rv", 32'(result_valid), 32'd0);
    end

    issue("addi_x0",  32'h0070_0013, 1'b0, 32'h0000_0007, 32'h120);
    issue("add_x0",   32'h0000_0333, 1'b0, 32'h0000_0000, 32'h124);
    issue("read_x5",  32'h0002_8433, 1'b0, 32'h0000_0120, 32'h128);
    issue("beq_nt",   32'h0020_8463, 1'b0, 32'h0000_0000, 32'h12C);
    issue("lui",      32'h1234_5537, 1'b0, 32'h1234_5000, 32'h130);
    issue("jalr",     32'h0002_84E7, 1'b0, 32'h0000_0134, 32'h120);
    issue("jalr_rd1", 32'h0082_82E7, 1'b0, 32'h0000_0124, 32'h128);
`ifdef RVCORE_MUL_EN
    issue("mul",      32'h0220_83B3, 1'b0, 32'hFFFF_FFF1, 32'h12C);
`else
    issue("mul",      32'h0220_83B3, 1'b1, 32'h0000_0000, 32'h128);
`endif

    // RV32E bound: x20 is illegal, core halts and ignores the port
    do_reset("r1");
    issue("addi_x20", 32'h0010_0A13, 1'b1, 32'h0000_0000, 32'h100);
    instr_valid = 1'b1;
    instruction = 32'h0050_0093;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halt_rdy", 32'(instr_ready), 32'd0);
      check("halt_ill", 32'(illegal), 32'd1);
      check("halt_pc", pc, 32'h100);
      check("halt_rv", 32'(result_valid), 32'd0);
    end
    instr_valid = 1'b0;

    // Misaligned taken branch target halts with pc on the branch
    do_reset("r2");
    issue("addi_a",   32'h0050_0093, 1'b0, 32'h0000_0005, 32'h104);
    issue("beq_mis",  32'h0000_0363, 1'b1, 32'h0000_0000, 32'h104);

    // Reset during EXEC discards the in-flight ADDI x7,x0,9
    do_reset("r3");
    issue("addi_b",   32'h0050_0093, 1'b0, 32'h0000_0005, 32'h104);
    wait_ready("rexec");
    instr_valid = 1'b1;
    instruction = 32'h0090_0393;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rexec_rdy", 32'(instr_ready), 32'd0);
    @(negedge clk);
    check("rexec_rv", 32'(result_valid), 32'd0);
    check("rexec_res", result, 32'd0);
    check("rexec_pc", pc, 32'h100);
    check("rexec_ill", 32'(illegal), 32'd0);
    reset = 1'b0;
    #1;
    check("rexec_rdy1", 32'(instr_ready), 32'd1);
    @(negedge clk);
    check("rexec_rv1", 32'(result_valid), 32'd0);
    issue("read_x7",  32'h0003_8433, 1'b0, 32'h0000_0000, 32'h104);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_core.md
# rv_multicycle_core

Parametrised multi-cycle RV32 integer core, the successor of the single-cycle nanocore. It fetches one instruction per valid/ready handshake, executes it in a dedicated cycle, and presents the rd writeback value on a qualified result port. Relative to the nanocore it adds:
- A handshake on the instruction port.
- A configurable register file depth (RV32I or RV32E).
- A larger ALU, branch and jump set.
- Illegal-instruction halting.

## Interface
- `RESET_PC`, default 32'h0000_0000: value loaded into pc on reset.
- `NUM_REGS`, default 32: register file depth. Legal values are 32 (RV32I) or 16 (RV32E).
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `instr_valid`  in  1: `instruction` holds the word at address pc.
- `instr_ready`  out  1: core accepts an instruction this cycle.
- `instruction`  in  32: instruction word.
- `pc`  out  32: address of the instruction being fetched or executed.
- `result`  out  32: last writeback value.
- `result_valid`  out  1: one-cycle pulse marking `result` as new.
- `illegal`  out  1: sticky flag; the core is halted.

## Operation
- **Register file.** NUM_REGS x 32 bits.
  - x0 always reads 0; writes to x0 are discarded.
  - All registers clear to 0 on reset.
- **FSM states.**
  - FETCH: `instr_ready`=1. If `instr_valid` is high, latch `instruction` and go to EXEC. Otherwise stay in FETCH.
  - EXEC: decode and execute the latched word, write rd, update pc and `result`, then go to FETCH. If the word is illegal, go to HALT instead.
  - HALT: `instr_ready`=0, `illegal`=1. Only `reset` exits this state.
- **Supported instructions.**
  - R-type (opcode 0110011): ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA. Shift amount is rs2[4:0].
  - I-type ALU (opcode 0010011): ADDI, ANDI, ORI, XORI, SLTI, SLTIU, SLLI, SRLI, SRAI. The immediate is sign-extended from instr[31:20].
  - LUI (opcode 0110111): rd = {instr[31:12], 12'b0}.
  - JAL: rd = pc+4; pc = pc + sign-extended J-immediate.
  - JALR: rd = pc+4; pc = (rs1 + I-immediate) with bit 0 cleared. rs1 is read before rd is written, so rd==rs1 works.
  - Branches (opcode 1100011): BEQ, BNE, BLT, BGE, BLTU, BGEU. If taken, pc = pc + B-immediate; otherwise pc = pc+4.
  - All other instructions: pc = pc+4.
- **Arithmetic.** All arithmetic is modulo 2^32. Signed compares use two's complement.
- **`result` per instruction class.**
  - Instructions that write rd: the value written, including when rd is x0.
  - Branches: {31'b0, taken}.
- **Illegal instructions.** The following are illegal:
  - Any unlisted opcode, funct3 or funct7 combination.
  - Any rs1, rs2 or rd index >= NUM_REGS.
  - Taken branch or jump targets whose bits [1:0] are not 00.

  On an illegal instruction the core makes no register write, leaves pc unchanged (pointing at the offending word), raises no `result_valid`, and enters HALT.

## Timing
- **Reset values.** In the cycle after `reset` is sampled high:
  - pc=RESET_PC, `result`=0, `result_valid`=0, `illegal`=0.
  - `instr_ready`=0 while `reset` is high.
  - State=FETCH, so `instr_ready`=1 from the first cycle with `reset` low.
- **Execution timing.** Handshake in cycle N (`instr_valid` and `instr_ready` both high).
  - EXEC in cycle N+1, with `instr_ready`=0.
  - The updates to pc, rd and `result`, and `result_valid`=1, are visible in cycle N+2.
  - `instr_ready`=1 again in cycle N+2.
- **Throughput.** At most one instruction per 2 cycles.
- **Stalls.** `instr_valid` low stalls the core in FETCH indefinitely with pc stable. `result_valid` is low during stalls.
- **Unused input.** `instruction` is ignored in EXEC and HALT, even if `instr_valid` is high.
- **Reset during EXEC.** The in-flight instruction is discarded: no register write and no `result_valid`. Reset values apply.
- **Reset in HALT.** Clears `illegal` and returns to FETCH.
- **pc wrap-around.** pc+4 from 32'hFFFF_FFFC wraps to 0. This is legal.

## Configuration
- **`RVCORE_MUL_EN` defined:** R-type funct7=0000001, funct3=000 is MUL. rd receives the low 32 bits of rs1*rs2, and the instruction still completes in the single EXEC cycle.
- **`RVCORE_MUL_EN` not defined:** that encoding is illegal (HALT, `illegal`=1). No multiplier is synthesised.

## Test plan
- **Reset and ALU.** With RESET_PC=32'h100, apply reset, then ADDI x1,x0,5 and ADDI x2,x0,-3.
  - Expect `result`=5, then 32'hFFFF_FFFD.
  - Expect pc=32'h104, then 32'h108.
  - Expect a `result_valid` pulse for each, 2 cycles after each handshake.
- **Signed and unsigned compares, shift.** With x1=5 and x2=-3:
  - SLT x3,x2,x1 -> `result`=1.
  - SLTU x3,x2,x1 -> `result`=0.
  - SRAI x4,x2,1 -> `result`=32'hFFFF_FFFE.
- **Branches and jumps.**
  - BNE x1,x2,+16 at pc=32'h10C -> pc=32'h11C, `result`=1.
  - JAL x5,-8 at pc=32'h11C -> x5=32'h120, pc=32'h114.
- **Stall and x0.** Hold `instr_valid` low for 5 cycles: pc is stable and `result_valid` stays 0. Then ADDI x0,x0,7 -> `result`=7, and a following ADD x6,x0,x0 -> `result`=0.
- **Illegal and RV32E bounds.** With NUM_REGS=16, issue ADDI x20,x0,1.
  - Expect `illegal`=1, pc unchanged and `instr_ready`=0 for 10 cycles.
  - Reset clears `illegal` and restores pc=RESET_PC.
- **Macro and reset during EXEC.** MUL x7,x1,x2 with x1=5, x2=-3:
  - With `RVCORE_MUL_EN`: `result`=32'hFFFF_FFF1.
  - Without it: `illegal`=1.
  - Asserting `reset` during EXEC leaves x7 unwritten and produces no `result_valid`.
